// File: rtl/sync_fifo_pkg.sv
// Shared sizing for the single-clock FIFO: default geometry and helpers
// that derive depth and pointer width from the address width.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // One extra wrap bit distinguishes full from empty when the low bits match.
  function automatic int unsigned fifo_ptr_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

  localparam int unsigned DEPTH     = fifo_depth(DEFAULT_ADDR_WIDTH);
  localparam int unsigned PTR_WIDTH = fifo_ptr_width(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is not reset; only the read data register is.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: wrap-bit pointers, combinational full/empty flags,
// and accept gating so writes-when-full and reads-when-empty are dropped.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PtrW = fifo_ptr_width(ADDR_WIDTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            wr_accept;
  logic            rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed bench for sync_fifo_core (8-bit data, 32 entries): reset, fill,
// drain, wrap, simultaneous access and mid-operation reset.
module tb_sync_fifo_core;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sync_fifo_core #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic exp_empty, input logic exp_full);
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, exp_empty});
    check({tag, ".full"},  {31'd0, full},  {31'd0, exp_full});
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    // Reset held for 50 time units
    for (int t = 0; t < 5; t++) begin
      #9;
      check_flags($sformatf("reset_t%0d", t), 1'b1, 1'b0);
      check($sformatf("reset_t%0d.data_out", t), {24'd0, data_out}, 32'h0);
    end
    #5;
    rst_n = 1'b1;
    step();
    check_flags("post_reset", 1'b1, 1'b0);

    // Fill 0..31
    for (int i = 0; i < 32; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(i);
      step();
      check_flags($sformatf("fill%0d", i), 1'b0, i == 31);
    end
    data_in = 8'd32;
    step();
    check_flags("write_when_full", 1'b0, 1'b1);
    wr_en = 1'b0;

    // Drain 0..31; the dropped 32 must never appear
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      step();
      check($sformatf("drain%0d.data", i), {24'd0, data_out}, 32'(i));
      check_flags($sformatf("drain%0d", i), i == 31, 1'b0);
    end
    step();
    check("read_when_empty.data", {24'd0, data_out}, 32'd31);
    check_flags("read_when_empty", 1'b1, 1'b0);
    rd_en = 1'b0;

    // Two more fill/drain rounds crossing pointer wrap
    for (int r = 1; r <= 2; r++) begin
      for (int c = 0; c < 64; c++) begin
        if (c < 32) begin
          wr_en   = 1'b1;
          rd_en   = 1'b0;
          data_in = 8'(r * 50 + c);
          step();
          if (c == 0 || c == 31)
            check_flags($sformatf("wrap%0d_w%0d", r, c), 1'b0, c == 31);
        end else begin
          wr_en = 1'b0;
          rd_en = 1'b1;
          step();
          check($sformatf("wrap%0d_r%0d.data", r, c), {24'd0, data_out}, 32'(r * 50 + c - 32));
          if (c == 32 || c == 63)
            check_flags($sformatf("wrap%0d_r%0d", r, c), c == 63, 1'b0);
        end
      end
    end
    rd_en = 1'b0;

    // Ten words stored, then 20 simultaneous read+write cycles
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(200 + i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 8'(210 + k);
      step();
      check($sformatf("simul%0d.data", k), {24'd0, data_out}, 32'(200 + k));
      check_flags($sformatf("simul%0d", k), 1'b0, 1'b0);
    end
    rd_en = 1'b0;

    // Top up to full (220..229 remain, add 230..251), then simultaneous while full
    for (int i = 0; i < 22; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(230 + i);
      step();
    end
    check_flags("topup_full", 1'b0, 1'b1);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'hEE;
    step();
    check("simul_full.data", {24'd0, data_out}, 32'd220);
    check_flags("simul_full", 1'b0, 1'b0);
    wr_en = 1'b0;
    for (int i = 0; i < 31; i++) begin
      rd_en = 1'b1;
      step();
      check($sformatf("after_full%0d.data", i), {24'd0, data_out},
            (i < 9) ? 32'(221 + i) : 32'(230 + i - 9));
    end
    check_flags("after_full_drained", 1'b1, 1'b0);
    rd_en = 1'b0;

    // 17 words stored, then asynchronous reset mid-operation
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      data_in = 8'(16 + i);
      step();
    end
    wr_en = 1'b0;
    check_flags("pre_midreset", 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_flags("midreset", 1'b1, 1'b0);
    check("midreset.data", {24'd0, data_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    wr_en   = 1'b1;
    data_in = 8'h5A;
    step();
    check_flags("post_midreset_wr", 1'b0, 1'b0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    check("post_midreset_rd.data", {24'd0, data_out}, 32'h5A);
    check_flags("post_midreset_rd", 1'b1, 1'b0);
    rd_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
